// File: rtl/sprite_anim_select.sv
// Two-stage registered sprite source select with vsync-driven animation pairing and
// background substitution for transparent pixels. Every output comes straight from a flop.
module sprite_anim_select #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      NUM_SRC     = 32,
    parameter int unsigned      SEL_W       = $clog2(NUM_SRC),
    parameter int unsigned      BKG_IDX     = 31,
    parameter logic [WIDTH-1:0] TRANSPARENT = '0,
    parameter int unsigned      ANIM_DIV    = 30
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               pix_valid_in,
    input  logic [WIDTH-1:0]   IN [NUM_SRC],
    input  logic [SEL_W-1:0]   S,
    input  logic [NUM_SRC-1:0] anim_mask,
    input  logic               vsync,
    input  logic               anim_freeze,
    output logic [WIDTH-1:0]   OUT,
    output logic               out_valid,
    output logic               out_transparent,
    output logic               frame_bit
);

    localparam int unsigned      CNT_W    = $clog2(ANIM_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    logic             r_vs_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_bit;

    logic             r_v1;
    logic [WIDTH-1:0] r_sel_pix;
    logic [WIDTH-1:0] r_bkg_pix;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_out_transparent;

    logic             w_vs_edge;
    logic             w_s_in_range;
    logic             w_s_not_last;
    logic             w_anim;
    logic [SEL_W-1:0] w_eff;
    logic [WIDTH-1:0] w_sel_pix;

    always_comb begin
        w_vs_edge    = vsync & ~r_vs_d;
        w_s_in_range = (32'(S) < NUM_SRC);
        w_s_not_last = (32'(S) < (NUM_SRC - 1));
        // The top source never pairs upward, so its mask bit is a don't-care.
        w_anim       = w_s_in_range && anim_mask[S] && r_frame_bit && w_s_not_last;
        w_eff        = w_anim ? (S + SEL_W'(1)) : S;
        w_sel_pix    = w_s_in_range ? IN[w_eff] : '0;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_vs_d            <= 1'b0;
            r_cnt             <= '0;
            r_frame_bit       <= 1'b0;
            r_v1              <= 1'b0;
            r_sel_pix         <= '0;
            r_bkg_pix         <= '0;
            r_out_valid       <= 1'b0;
            r_out             <= '0;
            r_out_transparent <= 1'b0;
        end else begin
            r_vs_d <= vsync;

            // Edges seen while frozen are dropped, not deferred.
            if (w_vs_edge && !anim_freeze) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt       <= '0;
                    r_frame_bit <= ~r_frame_bit;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            r_v1      <= pix_valid_in;
            r_sel_pix <= w_sel_pix;
            r_bkg_pix <= IN[BKG_IDX];

            r_out_valid <= r_v1;
            if (r_v1 && (r_sel_pix == TRANSPARENT)) begin
                r_out             <= r_bkg_pix;
                r_out_transparent <= 1'b1;
            end else if (r_v1) begin
                r_out             <= r_sel_pix;
                r_out_transparent <= 1'b0;
            end else begin
                r_out             <= '0;
                r_out_transparent <= 1'b0;
            end
        end
    end

    assign OUT             = r_out;
    assign out_valid       = r_out_valid;
    assign out_transparent = r_out_transparent;
    assign frame_bit       = r_frame_bit;

endmodule

// File: tb/tb_sprite_anim_select.sv
// Scoreboard bench for sprite_anim_select: the driver queues hand-computed pixels with their
// due cycle, and an independent monitor pops and compares whenever out_valid is seen.
module tb_sprite_anim_select;

    logic        clk;
    logic        axi_aresetn;
    logic        pix_valid_in;
    logic [3:0]  in_arr [32];
    logic [4:0]  S;
    logic [31:0] anim_mask;
    logic        vsync;
    logic        anim_freeze;
    logic [3:0]  OUT;
    logic        out_valid;
    logic        out_transparent;
    logic        frame_bit;

    sprite_anim_select #(
        .WIDTH      (4),
        .NUM_SRC    (32),
        .SEL_W      (5),
        .BKG_IDX    (31),
        .TRANSPARENT(4'h0),
        .ANIM_DIV   (2)
    ) dut (
        .axi_aclk       (clk),
        .axi_aresetn    (axi_aresetn),
        .pix_valid_in   (pix_valid_in),
        .IN             (in_arr),
        .S              (S),
        .anim_mask      (anim_mask),
        .vsync          (vsync),
        .anim_freeze    (anim_freeze),
        .OUT            (OUT),
        .out_valid      (out_valid),
        .out_transparent(out_transparent),
        .frame_bit      (frame_bit)
    );

    typedef struct {
        int         due;
        logic [3:0] pix;
        logic       tr;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    logic mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected pixel per out_valid and checks it arrived on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got OUT=%0h with nothing pending, cycle %0d",
                             OUT, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("out_pix", 32'(OUT), 32'(e.pix));
                    chk("out_transparent", 32'(out_transparent), 32'(e.tr));
                end
            end else begin
                chk("idle_out", 32'(OUT), 32'h0);
                chk("idle_transparent", 32'(out_transparent), 32'h0);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    n_chk++;
                    n_err++;
                    $display("FAIL missing_valid: got out_valid=0 expected pixel %0h due cycle %0d",
                             e.pix, e.due);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] s, input logic vs,
                         input logic [3:0] ep, input logic et);
        pix_valid_in = v;
        S            = s;
        vsync        = vs;
        if (v) q.push_back('{due: cyc + 2, pix: ep, tr: et});
    endtask

    // One idle cycle driving vsync; fb is the frame_bit expected from earlier cycles.
    task automatic cyc_vs(input logic vs, input logic fb);
        next();
        chk("frame_bit", 32'(frame_bit), 32'(fb));
        issue(1'b0, 5'd0, vs, 4'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_aresetn  = 1'b0;
        pix_valid_in = 1'b0;
        S            = '0;
        anim_mask    = '0;
        vsync        = 1'b0;
        anim_freeze  = 1'b0;
        for (int i = 0; i < 32; i++) in_arr[i] = 4'(i);
        in_arr[31] = 4'h5;

        // Reset then idle
        for (int i = 0; i < 3; i++) next();
        axi_aresetn = 1'b1;
        mon_en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            chk("reset_valid", 32'(out_valid), 32'h0);
            chk("reset_out", 32'(OUT), 32'h0);
            chk("reset_frame_bit", 32'(frame_bit), 32'h0);
        end

        // Plain select, single pulse
        next(); in_arr[3] = 4'hA; issue(1'b1, 5'd3, 1'b0, 4'hA, 1'b0);
        next(); issue(1'b0, 5'd3, 1'b0, 4'h0, 1'b0);
        next(); issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);

        // Transparency substitution, back-to-back
        next(); in_arr[7] = 4'h0; issue(1'b1, 5'd7, 1'b0, 4'h5, 1'b1);
        next(); in_arr[7] = 4'h2; issue(1'b1, 5'd7, 1'b0, 4'h2, 1'b0);
        next(); issue(1'b1, 5'd31, 1'b0, 4'h5, 1'b0);
        next(); in_arr[31] = 4'h0; issue(1'b1, 5'd31, 1'b0, 4'h0, 1'b1);
        next(); in_arr[31] = 4'h5; issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);

        // Animation pair 7/8 with S=7 held valid; pixel on a toggling edge sees old frame
        next();
        anim_mask[7] = 1'b1; in_arr[7] = 4'h1; in_arr[8] = 4'h9;
        issue(1'b1, 5'd7, 1'b0, 4'h1, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b1, 4'h1, 1'b0);
        next(); chk("anim_fb_e1", 32'(frame_bit), 32'h0); issue(1'b1, 5'd7, 1'b0, 4'h1, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b1, 4'h1, 1'b0);
        next(); chk("anim_fb_e2", 32'(frame_bit), 32'h1); issue(1'b1, 5'd7, 1'b0, 4'h9, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b1, 4'h9, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b0, 4'h9, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b1, 4'h9, 1'b0);
        next(); chk("anim_fb_e4", 32'(frame_bit), 32'h0); issue(1'b1, 5'd7, 1'b0, 4'h1, 1'b0);
        next(); issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);

        // Top-index mask bit ignored with frame_bit=1
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b0);
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b1);
        next();
        in_arr[31] = 4'hC; in_arr[0] = 4'h3; anim_mask[31] = 1'b1;
        issue(1'b1, 5'd31, 1'b0, 4'hC, 1'b0);
        next(); issue(1'b1, 5'd7, 1'b0, 4'h9, 1'b0);
        next(); issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);

        // vsync held high for 10 cycles is one edge
        for (int i = 0; i < 10; i++) cyc_vs(1'b1, 1'b1);
        cyc_vs(1'b0, 1'b1);
        cyc_vs(1'b1, 1'b1);
        cyc_vs(1'b0, 1'b0);

        // Freeze across 5 edges, then the counter must still be at 0
        anim_freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc_vs(1'b1, 1'b0);
            cyc_vs(1'b0, 1'b0);
        end
        anim_freeze = 1'b0;
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b0);
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b1);

        // Leave counter at 1, then reset mid-stream
        cyc_vs(1'b1, 1'b1);
        cyc_vs(1'b0, 1'b1);
        next(); issue(1'b1, 5'd3, 1'b0, 4'hA, 1'b0);
        next(); issue(1'b1, 5'd3, 1'b0, 4'hA, 1'b0);
        next();
        axi_aresetn = 1'b0;
        issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        next();
        axi_aresetn = 1'b1;
        chk("midreset_valid_1", 32'(out_valid), 32'h0);
        chk("midreset_frame_bit", 32'(frame_bit), 32'h0);
        issue(1'b1, 5'd3, 1'b0, 4'hA, 1'b0);
        next();
        chk("midreset_valid_2", 32'(out_valid), 32'h0);
        issue(1'b1, 5'd3, 1'b0, 4'hA, 1'b0);
        next(); issue(1'b0, 5'd0, 1'b0, 4'h0, 1'b0);
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b0);
        cyc_vs(1'b1, 1'b0);
        cyc_vs(1'b0, 1'b1);

        for (int i = 0; i < 5; i++) next();
        chk("drain_pending", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
